// File: rtl/idct_1d_seq.sv
// Inverse 8-point 1-D DCT, one output pixel per cycle.
// Eight shift-add constant multipliers and one adder tree are shared across the row.
module idct_1d_seq #(
   parameter int unsigned SHIFT = 5,
   parameter int unsigned ACC_W = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StCompute, StOut} state_t;

   localparam logic signed [ACC_W-1:0] Half = ACC_W'(2 ** (SHIFT - 1));

   state_t                  state_q;
   logic [2:0]              cnt_q;
   logic [63:0]             coef_q;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] rnd;
   logic [7:0]              pixel;

   // z times C_idx (Q7) using shifts and adds only.
   function automatic logic signed [ACC_W-1:0] cmul(input logic signed [7:0] z,
                                                    input logic [3:0] idx);
      logic signed [ACC_W-1:0] zx;
      logic signed [ACC_W-1:0] r;
      zx = ACC_W'(z);
      case (idx)
         4'd0:    r = zx <<< 7;
         4'd1:    r = (zx <<< 7) - (zx <<< 1);
         4'd2:    r = (zx <<< 7) - (zx <<< 3) - (zx <<< 1);
         4'd3:    r = (zx <<< 7) - (zx <<< 4) - (zx <<< 2) - (zx <<< 1);
         4'd4:    r = (zx <<< 6) + (zx <<< 4) + (zx <<< 3) + (zx <<< 1) + zx;
         4'd5:    r = (zx <<< 6) + (zx <<< 3) - zx;
         4'd6:    r = (zx <<< 5) + (zx <<< 4) + zx;
         4'd7:    r = (zx <<< 4) + (zx <<< 3) + zx;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Z[k] * T[k][n]; the phase (2n+1)k mod 32 is built by repeated addition of 2k.
   function automatic logic signed [ACC_W-1:0] term(input logic signed [7:0] z,
                                                    input int unsigned k,
                                                    input logic [2:0] n);
      logic [4:0]              p;
      logic [3:0]              idx;
      logic                    neg;
      logic signed [ACC_W-1:0] prod;
      p = 5'(k);
      for (int i = 0; i < 7; i++) begin
         if (3'(i) < n) p = p + 5'(k << 1);
      end
      if (p > 5'd16) p = 5'd0 - p;
      neg = (p > 5'd8);
      idx = neg ? 4'(5'd16 - p) : p[3:0];
      if (k == 0) begin
         neg = 1'b0;
         idx = 4'd4;
      end
      prod = cmul(z, idx);
      return neg ? -prod : prod;
   endfunction

   always_comb begin
      acc = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         acc = acc + term(coef_q[8*(7-k) +: 8], k, cnt_q);
      end
      rnd = (acc + Half) >>> SHIFT;
      if (rnd[ACC_W-1]) begin
         pixel = 8'd0;
      end else if (|rnd[ACC_W-2:8]) begin
         pixel = 8'hff;
      end else begin
         pixel = rnd[7:0];
      end
   end

   assign in_ready = (state_q == StIdle) || ((state_q == StOut) && out_ready);
   assign busy     = (state_q == StCompute);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 3'd0;
         coef_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  coef_q  <= in_data;
                  cnt_q   <= 3'd0;
                  state_q <= StCompute;
               end
            end
            StCompute: begin
               // pixel n lands in byte n, counted from the MSB end
               out_data[{~cnt_q, 3'b000} +: 8] <= pixel;
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_q   <= StOut;
                  out_valid <= 1'b1;
               end
            end
            StOut: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     coef_q  <= in_data;
                     cnt_q   <= 3'd0;
                     state_q <= StCompute;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_idct_1d_seq.sv
// Directed and random checks of idct_1d_seq against an arithmetic reference of the IDCT.
module tb_idct_1d_seq;

   localparam int SHIFT = 5;
   localparam int ACC_W = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   idct_1d_seq #(.SHIFT(SHIFT), .ACC_W(ACC_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_row(input logic [63:0] d);
      int c[9];
      int acc, z, p, t, r;
      logic [63:0] res;
      c = '{128, 126, 118, 106, 91, 71, 49, 25, 0};
      res = '0;
      for (int n = 0; n < 8; n++) begin
         acc = 0;
         for (int k = 0; k < 8; k++) begin
            z = int'($signed(d[63-8*k -: 8]));
            if (k == 0) begin
               t = 91;
            end else begin
               p = ((2 * n + 1) * k) % 32;
               if (p > 16) p = 32 - p;
               t = (p <= 8) ? c[p] : -c[16-p];
            end
            acc += z * t;
         end
         r = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
         if (r < 0) r = 0;
         else if (r > 255) r = 255;
         res[63-8*n -: 8] = 8'(r);
      end
      return res;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Called just after the accepting edge; counts edges until out_valid.
   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 30) begin
         chk({tag, "_in_ready_compute"}, 64'(in_ready), 64'(0));
         tick;
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(8));
   endtask

   task automatic send_row(input logic [63:0] d, input string tag);
      chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1));
      in_data  = d;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      wait_out(tag);
      chk({tag, "_data"}, out_data, ref_row(d));
   endtask

   task automatic release_row(input string tag);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk({tag, "_released"}, 64'(out_valid), 64'(0));
   endtask

   initial begin
      logic [63:0] d1, d2;
      logic [63:0] rows[4];
      int idx, oi, cyc, last;
      logic acc_now;

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_data = '0;
      repeat (3) tick;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_data", out_data, 64'(0));
      rst = 1'b0;
      tick;

      send_row(64'h2D00_0000_0000_0000, "dc45");
      chk("dc45_lit", out_data, 64'h8080_8080_8080_8080);
      release_row("dc45");

      send_row(64'h0020_0000_0000_0000, "z1");
      chk("z1_x0", 64'(out_data[63:56]), 64'(126));
      chk("z1_x3", 64'(out_data[39:32]), 64'(25));
      chk("z1_x4", 64'(out_data[31:24]), 64'(0));
      chk("z1_x7", 64'(out_data[7:0]), 64'(0));
      release_row("z1");

      send_row(64'h7F00_0000_0000_0000, "z127");
      chk("z127_lit", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      release_row("z127");

      send_row(64'hF600_0000_0000_0000, "zneg");
      chk("zneg_lit", out_data, 64'h0);
      release_row("zneg");

      send_row(64'h0, "zero");
      chk("zero_lit", out_data, 64'h0);
      release_row("zero");

      for (int i = 0; i < 3; i++) begin
         send_row({$urandom, $urandom}, "rand");
         release_row("rand");
      end

      // Backpressure, then simultaneous output transfer and new accept.
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      send_row(d1, "bp");
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_hold_valid", 64'(out_valid), 64'(1));
         chk("bp_hold_data", out_data, ref_row(d1));
         chk("bp_hold_in_ready", 64'(in_ready), 64'(0));
      end
      in_data = d2;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_out", 64'(in_ready), 64'(1));
      tick;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("bp_xfer_valid", 64'(out_valid), 64'(0));
      chk("bp_xfer_busy", 64'(busy), 64'(1));
      wait_out("bp2");
      chk("bp2_data", out_data, ref_row(d2));
      release_row("bp2");

      // Streaming with both handshakes held high.
      for (int i = 0; i < 4; i++) rows[i] = {$urandom, $urandom};
      idx = 0;
      oi = 0;
      cyc = 0;
      last = 0;
      in_data = rows[0];
      in_valid = 1'b1;
      out_ready = 1'b1;
      while (oi < 4 && cyc < 100) begin
         acc_now = in_valid && in_ready;
         if (out_valid) begin
            chk("stream_data", out_data, ref_row(rows[oi]));
            if (oi > 0) chk("stream_gap", 64'(cyc - last), 64'(9));
            last = cyc;
            oi++;
         end
         tick;
         cyc++;
         if (acc_now) begin
            idx++;
            if (idx < 4) in_data = rows[idx];
            else in_valid = 1'b0;
         end
      end
      chk("stream_count", 64'(oi), 64'(4));
      in_valid = 1'b0;
      tick;
      out_ready = 1'b0;
      chk("stream_idle", 64'(in_ready), 64'(1));

      // Abort mid-COMPUTE at cnt==3.
      in_data = {$urandom, $urandom};
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (3) tick;
      chk("abort_busy_before", 64'(busy), 64'(1));
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_out_valid", 64'(out_valid), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_in_ready", 64'(in_ready), 64'(1));
      send_row({$urandom, $urandom}, "post_abort");
      release_row("post_abort");

      // Reset while a row is waiting in OUT.
      send_row({$urandom, $urandom}, "out_rst");
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("out_rst_valid", 64'(out_valid), 64'(0));
      chk("out_rst_data", out_data, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
